quad_step_decoder: RTL
======================

Name: quad_step_decoder

Overview:
- Converts a two-phase quadrature rotary encoder (board pins A/B) into single-cycle `up`/`down` step strobes.
- The strobes directly drive the up/down counter's `up`/`down` inputs.
- Handles pin synchronisation, per-channel debounce, Gray-sequence direction decode and detent division.
- Flags and counts illegal transitions.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per pin; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised level must differ from the stable level before it is accepted; legal range 1..65535.
- STEPS_PER_DETENT, 4: valid quadrature transitions per emitted strobe; legal values 1, 2, 4.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enc_a  input  1  encoder phase A, asynchronous to clock.
- enc_b  input  1  encoder phase B, asynchronous to clock.
- enable  input  1  when low, suppresses strobes and clears the step accumulator.
- up  output  1  one-cycle strobe, one clockwise detent.
- down  output  1  one-cycle strobe, one counter-clockwise detent.
- error  output  1  one-cycle strobe on an illegal transition (both phases changed at once).
- err_count  output  8  saturating count of illegal transitions.

Behaviour:
- Reset (async assert, sync release on clock):
  - up=0, down=0, error=0, err_count=0.
  - Synchroniser flops = 0, stable levels = 0, debounce counters = 0, accumulator = 0.
  - primed = 0.
- Synchroniser: SYNC_STAGES flops per pin; the last stage feeds the debouncer.
- Debounce, per channel, independent:
  - Counter increments while the synced level differs from the stable level.
  - Counter clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the new value on that edge and the counter clears.
- Priming:
  - The first stable {A,B} pair after reset is loaded as the reference phase, with no strobe and no error.
  - Priming occurs when the debounce counters have both seen DEBOUNCE_CYCLES matching-or-settled cycles; primed then goes to 1.
- Decode, on each cycle where the stable {A,B} differs from the reference:
  - CW sequence 00→01→11→10→00: accumulator +1.
  - CCW sequence (reverse): accumulator −1.
  - Both bits changed: error=1 for one cycle, err_count += 1 (saturates at 255, no wrap), accumulator cleared to 0.
  - In all three cases the reference is updated to the stable pair.
- Accumulator (signed, 3 bits):
  - Reaching +STEPS_PER_DETENT: up=1 on the next cycle; accumulator returns to 0 on the same edge.
  - Reaching −STEPS_PER_DETENT: down=1 on the next cycle; accumulator returns to 0 on the same edge.
  - A direction reversal mid-detent moves the accumulator back toward 0 with no strobe.
- Strobes are registered:
  - up and down are never both 1.
  - Each is high exactly one cycle per detent.
- Latency: a pin edge whose transition completes a detent produces its strobe SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks after the first clock edge that samples the new pin level. With defaults this is 19.
- enable=0:
  - up=down=0 and the accumulator is held at 0.
  - Synchroniser, debounce, reference tracking and error detection keep running.
  - Re-enabling produces no spurious strobe.
- Glitches shorter than DEBOUNCE_CYCLES are ignored and the stable level is unchanged.
- Simultaneous stable-level updates of A and B on the same cycle are treated as illegal (error path).
- Reset asserted mid-operation:
  - All state clears immediately; any strobe in flight is dropped.
  - After release, re-priming is required before decoding resumes.

Decomposition:
- Shared package quad_pkg:
  - Phase encodings PH_00, PH_01, PH_11, PH_10.
  - Direction enum DIR_NONE/DIR_CW/DIR_CCW/DIR_ILLEGAL.
  - ERR_COUNT_W=8.
  - Function next_dir(prev, curr) returning the direction enum.
- One natural sub-module, quad_debounce, instantiated once per phase:
  - Contains the synchroniser, debounce counter and stable level.
  - Parameters SYNC_STAGES, DEBOUNCE_CYCLES.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, SYNC_STAGES=2; STEPS_PER_DETENT=4 unless noted):
- Reset, then A/B held 11 → no strobes, error=0, err_count=0; priming is silent.
- Four CW phases 11→10→00→01→11, each held 10 cycles, enable=1 → exactly one up pulse, 7 clocks after the edge sampling the final phase; down stays 0.
- Same sequence reversed (CCW) → exactly one down pulse; 3 CW transitions followed by 3 CCW transitions → no strobes.
- 3-cycle glitch on A during hold → no strobe, no error; stable level unchanged.
- A and B toggled together 11→00, held → error pulses once and err_count=1. Repeated 300 times → err_count saturates at 255.
- STEPS_PER_DETENT=1, 8 CW transitions → 8 up pulses. Repeated with enable=0 → none, and re-asserting enable causes no pulse. reset_n pulsed low mid-sequence → outputs 0 immediately.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
//   ERR_COUNT_W : width of the saturating illegal-transition counter
//   PH_*        : phase encodings {A,B} in clockwise Gray order 00,01,11,10
//   dir_e       : decoded direction of one reference-to-stable change
//   state_e     : priming FSM states
//   next_dir()  : classifies a phase change as none / CW / CCW / illegal
package quad_pkg;

  localparam int unsigned ERR_COUNT_W = 8;
  localparam int unsigned PHASE_W     = 2;

  localparam logic [PHASE_W-1:0] PH_00 = 2'b00;
  localparam logic [PHASE_W-1:0] PH_01 = 2'b01;
  localparam logic [PHASE_W-1:0] PH_11 = 2'b11;
  localparam logic [PHASE_W-1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_CW      = 2'd1,
    DIR_CCW     = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Position of a phase within the clockwise cycle.
  function automatic logic [1:0] phase_idx(input logic [PHASE_W-1:0] ph);
    case (ph)
      PH_00:   phase_idx = 2'd0;
      PH_01:   phase_idx = 2'd1;
      PH_11:   phase_idx = 2'd2;
      default: phase_idx = 2'd3;
    endcase
  endfunction

  // A modulo-4 index step of 2 means both phases flipped at once.
  function automatic dir_e next_dir(input logic [PHASE_W-1:0] prev,
                                    input logic [PHASE_W-1:0] curr);
    logic [1:0] step;
    step = phase_idx(curr) - phase_idx(prev);
    case (step)
      2'd0:    next_dir = DIR_NONE;
      2'd1:    next_dir = DIR_CW;
      2'd3:    next_dir = DIR_CCW;
      default: next_dir = DIR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Per-pin synchroniser plus debouncer.
//   clk_i, rst_ni : clock, async active-low reset
//   pin_i         : raw asynchronous pin
//   stable_o      : debounced level (registered)
//   differ_c      : synchronised level currently differs from stable_o
module quad_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic stable_o,
  output logic differ_c
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign differ_c = synced != stable_q;
  assign stable_o = stable_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Accept the new level on the edge where the run of differing cycles hits the limit.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (differ_c) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder to up/down detent strobes.
//   clock, reset_n  : clock, async active-low reset
//   enc_a, enc_b    : raw encoder phases
//   enable          : low suppresses strobes and clears the accumulator
//   up, down        : one-cycle detent strobes
//   error           : one-cycle strobe on an illegal (double) phase change
//   err_count       : saturating count of illegal changes
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned STEPS_PER_DETENT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic                   enable,
  output logic                   up,
  output logic                   down,
  output logic                   error,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
  localparam logic [3:0] STEP_NEG = 4'(16 - STEPS_PER_DETENT);

  logic                   stable_a, stable_b, differ_a, differ_b;
  logic [PHASE_W-1:0]     stable_ab;
  state_e                 state_q, state_d;
  logic [PHASE_W-1:0]     ref_q, ref_d;
  dir_e                   dir_q, dir_d;
  logic [CNT_W-1:0]       prime_cnt_q, prime_cnt_d;
  logic [2:0]             acc_q, acc_d;
  logic [3:0]             acc_ext, acc_sum;
  logic                   up_q, up_d, down_q, down_d, err_q, err_d;
  logic [ERR_COUNT_W-1:0] err_cnt_q, err_cnt_d;

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk_i(clock), .rst_ni(reset_n), .pin_i(enc_a), .stable_o(stable_a), .differ_c(differ_a)
  );

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i(clock), .rst_ni(reset_n), .pin_i(enc_b), .stable_o(stable_b), .differ_c(differ_b)
  );

  assign stable_ab = {stable_a, stable_b};
  assign acc_ext   = {acc_q[2], acc_q};

  assign up        = up_q;
  assign down      = down_q;
  assign error     = err_q;
  assign err_count = err_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PRIME;
      ref_q       <= PH_00;
      dir_q       <= DIR_NONE;
      prime_cnt_q <= '0;
      acc_q       <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      dir_q       <= dir_d;
      prime_cnt_q <= prime_cnt_d;
      acc_q       <= acc_d;
      up_q        <= up_d;
      down_q      <= down_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Stage 1: priming / direction decode. Stage 2: accumulate registered direction.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    dir_d       = DIR_NONE;
    prime_cnt_d = prime_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    acc_d       = acc_q;
    acc_sum     = acc_ext;
    up_d        = 1'b0;
    down_d      = 1'b0;

    case (state_q)
      ST_PRIME: begin
        // Wait for both channels to sit quietly before adopting the reference phase.
        if (differ_a || differ_b) begin
          prime_cnt_d = '0;
        end else if (prime_cnt_q == PRIME_LAST) begin
          ref_d       = stable_ab;
          prime_cnt_d = '0;
          state_d     = ST_RUN;
        end else begin
          prime_cnt_d = prime_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (stable_ab != ref_q) begin
          dir_d = next_dir(ref_q, stable_ab);
          ref_d = stable_ab;
          if (dir_d == DIR_ILLEGAL) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_COUNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase

    if (!enable) begin
      acc_d = '0;
    end else begin
      case (dir_q)
        DIR_CW: begin
          acc_sum = acc_ext + 4'd1;
          if (acc_sum == STEP_POS) begin
            up_d  = 1'b1;
            acc_d = '0;
          end else begin
            acc_d = acc_sum[2:0];
          end
        end
        DIR_CCW: begin
          acc_sum = acc_ext - 4'd1;
          if (acc_sum == STEP_NEG) begin
            down_d = 1'b1;
            acc_d  = '0;
          end else begin
            acc_d = acc_sum[2:0];
          end
        end
        DIR_ILLEGAL: acc_d = '0;
        default:     acc_d = acc_q;
      endcase
    end
  end

endmodule
